// File: rtl/etpu_wb_stream_if.sv
// etpu_wb_stream_if: Wishbone slave bus plus operand/result streams and interrupt of etpu_wb_stream
interface etpu_wb_stream_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        a_valid_o;
   logic        a_ready_i;
   logic [31:0] a_data_o;
   logic        r_valid_i;
   logic        r_ready_o;
   logic [31:0] r_data_i;
   logic        irq_o;
   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, a_ready_i, r_valid_i, r_data_i,
      output wbs_ack_o, wbs_dat_o, a_valid_o, a_data_o, r_ready_o, irq_o
   );
   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, a_ready_i, r_valid_i, r_data_i,
      input  wbs_ack_o, wbs_dat_o, a_valid_o, a_data_o, r_ready_o, irq_o
   );
endinterface

// File: rtl/etpu_wb_stream.sv
// etpu_wb_stream: Wishbone FIFO bridge to the edu_tpu core; define ETPU_WB_IRQ_EN for the result interrupt
module etpu_wb_stream #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int IN_DEPTH = 8,
   parameter int OUT_DEPTH = 8
) (
   input logic clk,
   input logic RSTB,
   etpu_wb_stream_if.slave bus
);
   localparam int IW = $clog2(IN_DEPTH);
   localparam int OW = $clog2(OUT_DEPTH);
   localparam int IC = $clog2(IN_DEPTH + 1);
   localparam int OC = $clog2(OUT_DEPTH + 1);
   logic [31:0] in_mem [IN_DEPTH];
   logic [31:0] out_mem [OUT_DEPTH];
   logic [IW-1:0] in_wp, in_rp;
   logic [OW-1:0] out_wp, out_rp;
   logic [IC-1:0] in_cnt;
   logic [OC-1:0] out_cnt, out_cnt_nxt;
   logic enable, irq_en, overflow, underflow;
   logic req, wr_ctrl, flush, push, push_ok, pop_rd, pop_ok, a_pop, cap;
   logic in_full, in_empty, out_full, out_empty;
   logic [31:0] status, rdata;
   logic unused_adr;
   assign unused_adr = ^bus.wbs_adr_i[1:0];
   assign bus.a_valid_o = enable & !in_empty;
   assign bus.a_data_o = in_mem[in_rp];
   always_comb begin
      req = bus.wbs_stb_i & bus.wbs_cyc_i & (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]) & !bus.wbs_ack_o;
      wr_ctrl = req & bus.wbs_we_i & (bus.wbs_adr_i[3:2] == 2'd0) & bus.wbs_sel_i[0];
      flush = wr_ctrl & bus.wbs_dat_i[1];
      push = req & bus.wbs_we_i & (bus.wbs_adr_i[3:2] == 2'd2) & (bus.wbs_sel_i == 4'hF);
      pop_rd = req & !bus.wbs_we_i & (bus.wbs_adr_i[3:2] == 2'd3);
      in_full = in_cnt == IC'(IN_DEPTH);
      in_empty = in_cnt == '0;
      out_full = out_cnt == OC'(OUT_DEPTH);
      out_empty = out_cnt == '0;
      push_ok = push & !in_full;
      pop_ok = pop_rd & !out_empty;
      a_pop = bus.a_valid_o & bus.a_ready_i & !flush;
      cap = bus.r_valid_i & bus.r_ready_o & !flush;
      out_cnt_nxt = flush ? '0 : out_cnt + OC'(cap) - OC'(pop_ok);
      status = {10'd0, underflow, overflow, out_empty, out_full, in_empty, in_full, 8'(out_cnt), 8'(in_cnt)};
      rdata = bus.wbs_adr_i[3:2] == 2'd0 ? {29'd0, irq_en, 1'b0, enable} :
              bus.wbs_adr_i[3:2] == 2'd1 ? status :
              bus.wbs_adr_i[3:2] == 2'd3 ? (out_empty ? 32'h0 : out_mem[out_rp]) : 32'h0;
   end
   always_ff @(posedge clk) begin
      if (push_ok) in_mem[in_wp] <= bus.wbs_dat_i;
      if (cap) out_mem[out_wp] <= bus.r_data_i;
   end
   always_ff @(posedge clk) begin
      if (!RSTB) begin
         bus.wbs_ack_o <= 1'b0;
         bus.wbs_dat_o <= '0;
         bus.r_ready_o <= 1'b0;
         enable <= 1'b0;
         overflow <= 1'b0;
         underflow <= 1'b0;
         in_cnt <= '0;
         in_wp <= '0;
         in_rp <= '0;
         out_cnt <= '0;
         out_wp <= '0;
         out_rp <= '0;
      end else begin
         bus.wbs_ack_o <= req;
         bus.wbs_dat_o <= (req & !bus.wbs_we_i) ? rdata : '0;
         bus.r_ready_o <= out_cnt_nxt != OC'(OUT_DEPTH);
         if (wr_ctrl) enable <= bus.wbs_dat_i[0];
         overflow <= !flush & (overflow | (push & in_full));
         underflow <= !flush & (underflow | (pop_rd & out_empty));
         in_cnt <= flush ? '0 : in_cnt + IC'(push_ok) - IC'(a_pop);
         in_wp <= flush ? '0 : in_wp + IW'(push_ok);
         in_rp <= flush ? '0 : in_rp + IW'(a_pop);
         out_cnt <= out_cnt_nxt;
         out_wp <= flush ? '0 : out_wp + OW'(cap);
         out_rp <= flush ? '0 : out_rp + OW'(pop_ok);
      end
   end
`ifdef ETPU_WB_IRQ_EN
   always_ff @(posedge clk) begin
      if (!RSTB) begin
         irq_en <= 1'b0;
         bus.irq_o <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en <= bus.wbs_dat_i[2];
         bus.irq_o <= irq_en & !out_empty;
      end
   end
`else
   assign irq_en = 1'b0;
   assign bus.irq_o = 1'b0;
`endif
endmodule
